fifo_in_rd_statemachine: RTL

Read-side controller for FIFO_In. After the write side has filled FIFO_In with the noise window and the range-bin samples (two 16-bit samples per FIFO word), this block drains the FIFO one range bin at a time. It frames each bin with start/end markers for the downstream FFT stage and waits for FFT readiness at every bin boundary. It sits between FIFO_In's read port and the FFT input.

---
 rtl/fifo_in_rd_statemachine.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_in_rd_statemachine.sv
// Read-side controller for FIFO_In: drains one range bin at a time with sop/eop framing and FFT handshaking.
// Optional empty-stall watchdog enabled by defining RD_TIMEOUT_EN.
module fifo_in_rd_statemachine #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] nPointsPerBin,
    input  logic [7:0]  nRangeBins,
    input  logic        fifo_empty,
    input  logic        fft_ready,
    output logic        rd_en,
    output logic        data_valid,
    output logic        bin_sop,
    output logic        bin_eop,
    output logic [8:0]  bin_index,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        READ_BIN,
        BIN_GAP,
        DONE
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state;
    logic [14:0]      words_q;
    logic [14:0]      word_cnt;
    logic [8:0]       nbins_q;
    logic [8:0]       bin_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_word;
    logic             timeout_hit;
    logic             unused_lsb;

    // Two samples per FIFO word, so the sample-count LSB never matters.
    assign unused_lsb = nPointsPerBin[0];

    // NOTE: rd_en is decoded combinationally so the FIFO sees the read in the same cycle the empty flag is low.
    assign rd_en     = (state == READ_BIN) && !fifo_empty;
    assign busy      = (state != IDLE);
    assign last_word = (word_cnt == words_q - 15'd1);

`ifdef RD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (state == READ_BIN) && fifo_empty &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state == READ_BIN) && fifo_empty)
                to_cnt <= timeout_hit ? '0 : to_cnt + 1'b1;
            else
                to_cnt <= '0;
            if (timeout_hit)
                timeout_err <= 1'b1;
            else if ((state == IDLE) && start)
                timeout_err <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // NOTE: every register here uses <= so all updates see the pre-edge values of their neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            words_q    <= '0;
            nbins_q    <= '0;
            word_cnt   <= '0;
            bin_cnt    <= '0;
            gap_cnt    <= '0;
            data_valid <= 1'b0;
            bin_sop    <= 1'b0;
            bin_eop    <= 1'b0;
            bin_index  <= '0;
            done       <= 1'b0;
        end else begin
            // FIFO dout arrives one cycle after rd_en, so the framing flags ride one cycle behind it.
            data_valid <= rd_en;
            bin_sop    <= rd_en && (word_cnt == 15'd0);
            bin_eop    <= rd_en && last_word;
            if (rd_en)
                bin_index <= bin_cnt;
            done <= (state == DONE);

            case (state)
                IDLE: begin
                    if (start) begin
                        words_q  <= nPointsPerBin[15:1];
                        nbins_q  <= {1'b0, nRangeBins} + 9'd1;
                        word_cnt <= '0;
                        bin_cnt  <= '0;
                        gap_cnt  <= '0;
                        state    <= (nPointsPerBin[15:1] == 15'd0) ? DONE : WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (fft_ready)
                        state <= READ_BIN;
                end
                READ_BIN: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (rd_en) begin
                        if (last_word) begin
                            word_cnt <= '0;
                            bin_cnt  <= bin_cnt + 9'd1;
                            state    <= (bin_cnt < nbins_q - 9'd1) ? BIN_GAP : DONE;
                        end else begin
                            word_cnt <= word_cnt + 15'd1;
                        end
                    end
                end
                BIN_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        state   <= WAIT_READY;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
